// File: rtl/pid_term_gen.sv
`default_nettype none
// ============================================================================
// Module   : pid_term_gen
// Summary  : Turns setpoint/measurement samples into saturated signed 6-bit
//            P, I and D terms using shift-only gains, over a four-state
//            sequence.
// Option   : PID_TERM_GEN_ANTI_WINDUP_EN limits the integrator to the range
//            that the I term can represent after its shift.
// Revision : 1.0 - initial release
// ============================================================================
module pid_term_gen #(
   parameter int P_SHIFT = 0,
   parameter int I_SHIFT = 2,
   parameter int D_SHIFT = 0,
   parameter int ACC_W   = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [5:0] setpoint,
   input  logic [5:0] measurement,
   input  logic       sample_valid,
   input  logic       integ_clr,
   output logic       busy,
   output logic [5:0] p_contrib,
   output logic [5:0] i_contrib,
   output logic [5:0] d_contrib,
   output logic       contrib_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR  = 2'd1,
      S_UPD  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

`ifdef PID_TERM_GEN_ANTI_WINDUP_EN
   localparam int c_acc_hi = (32 << I_SHIFT) - 1;
   localparam int c_acc_lo = -(32 << I_SHIFT);
`else
   localparam int c_acc_hi = (1 << (ACC_W - 1)) - 1;
   localparam int c_acc_lo = -(1 << (ACC_W - 1));
`endif

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic signed [5:0]         r_sp;
   logic signed [5:0]         r_ms;
   logic signed [6:0]         r_err;
   logic signed [6:0]         r_e_prev;
   logic                      r_primed;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [5:0]         r_p;
   logic signed [5:0]         r_i;
   logic signed [5:0]         r_d;
   logic                      r_valid;

   logic signed [6:0]         w_err;
   logic signed [ACC_W-1:0]   w_acc_base;
   logic                      w_primed_base;
   logic signed [31:0]        w_sum;
   logic signed [ACC_W-1:0]   w_acc_upd;
   logic signed [7:0]         w_diff;

   function automatic logic signed [5:0] sat6(input logic signed [31:0] v);
      if (v > 31)
         return 6'b011111;
      else if (v < -32)
         return 6'b100000;
      else
         return v[5:0];
   endfunction

   assign w_err = 7'(r_sp) - 7'(r_ms);

   // A clear raised during UPD must take effect before this sample's update.
   assign w_acc_base    = integ_clr ? '0 : r_acc;
   assign w_primed_base = integ_clr ? 1'b0 : r_primed;
   assign w_sum         = 32'(w_acc_base) + 32'(r_err);
   assign w_diff        = w_primed_base ? (8'(r_err) - 8'(r_e_prev)) : 8'sd0;

   always_comb begin
      if (w_sum > c_acc_hi)
         w_acc_upd = ACC_W'(c_acc_hi);
      else if (w_sum < c_acc_lo)
         w_acc_upd = ACC_W'(c_acc_lo);
      else
         w_acc_upd = ACC_W'(w_sum);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (sample_valid && !integ_clr) w_state_nxt = S_ERR;
         S_ERR:   w_state_nxt = S_UPD;
         S_UPD:   w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sp     <= '0;
         r_ms     <= '0;
         r_err    <= '0;
         r_e_prev <= '0;
         r_primed <= 1'b0;
         r_acc    <= '0;
         r_p      <= '0;
         r_i      <= '0;
         r_d      <= '0;
         r_valid  <= 1'b0;
      end else begin
         // The pulse lasts one clock even if ena drops while in OUT.
         r_valid <= 1'b0;
         if (ena) begin
            r_state <= w_state_nxt;
            case (r_state)
               S_IDLE: begin
                  if (w_state_nxt == S_ERR) begin
                     r_sp <= $signed(setpoint);
                     r_ms <= $signed(measurement);
                  end
               end
               S_ERR: r_err <= w_err;
               S_UPD: begin
                  r_acc    <= w_acc_upd;
                  r_e_prev <= r_err;
                  r_primed <= 1'b1;
                  r_p      <= sat6(32'(r_err >>> P_SHIFT));
                  r_i      <= sat6(32'(w_acc_upd >>> I_SHIFT));
                  r_d      <= sat6(32'(w_diff >>> D_SHIFT));
                  r_valid  <= 1'b1;
               end
               default: ;
            endcase
            if (integ_clr && r_state != S_UPD) begin
               r_acc    <= '0;
               r_e_prev <= '0;
               r_primed <= 1'b0;
            end
         end
      end
   end

   assign busy          = (r_state == S_ERR) || (r_state == S_UPD);
   assign p_contrib     = r_p;
   assign i_contrib     = r_i;
   assign d_contrib     = r_d;
   assign contrib_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pid_term_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_term_gen
// Summary  : Directed self-checking bench for pid_term_gen with hand-derived
//            expected terms; honours PID_TERM_GEN_ANTI_WINDUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_term_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [5:0] setpoint;
   logic [5:0] measurement;
   logic       sample_valid;
   logic       integ_clr;
   logic       busy;
   logic [5:0] p_contrib;
   logic [5:0] i_contrib;
   logic [5:0] d_contrib;
   logic       contrib_valid;

   int errors = 0;
   int checks = 0;

   pid_term_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .setpoint      (setpoint),
      .measurement   (measurement),
      .sample_valid  (sample_valid),
      .integ_clr     (integ_clr),
      .busy          (busy),
      .p_contrib     (p_contrib),
      .i_contrib     (i_contrib),
      .d_contrib     (d_contrib),
      .contrib_valid (contrib_valid)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sx6(input logic [5:0] v);
      return int'($signed(v));
   endfunction

   task automatic do_reset();
      rst_n        = 1'b0;
      ena          = 1'b1;
      sample_valid = 1'b0;
      integ_clr    = 1'b0;
      setpoint     = '0;
      measurement  = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Called at posedge+1 with the DUT idle; leaves it idle at posedge+1.
   task automatic send(input string tag, input int sp, input int ms,
                       input int ep, input int ei, input int ed, input bit clr);
      int cnt;
      int busyc;
      setpoint     = 6'(sp);
      measurement  = 6'(ms);
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      integ_clr    = clr;
      cnt   = 1;
      busyc = 0;
      while (!contrib_valid && cnt < 20) begin
         if (busy) busyc++;
         @(posedge clk); #1;
         integ_clr = 1'b0;
         cnt++;
      end
      check({tag, ".lat"},  cnt, 3);
      check({tag, ".busy"}, busyc, 2);
      check({tag, ".bfall"}, int'(busy), 0);
      check({tag, ".P"}, sx6(p_contrib), ep);
      check({tag, ".I"}, sx6(i_contrib), ei);
      check({tag, ".D"}, sx6(d_contrib), ed);
      @(posedge clk); #1;
      check({tag, ".pulse"}, int'(contrib_valid), 0);
      check({tag, ".holdP"}, sx6(p_contrib), ep);
   endtask

   initial begin
      int acc_m;
      int hi;
      int n, first, last, cnt, bc, vc;

      do_reset();
      check("rst.P", sx6(p_contrib), 0);
      check("rst.I", sx6(i_contrib), 0);
      check("rst.D", sx6(d_contrib), 0);
      check("rst.valid", int'(contrib_valid), 0);
      check("rst.busy", int'(busy), 0);

      send("basic",  20, 10, 10, 2, 0, 1'b0);
      send("repeat", 20, 10, 10, 5, 0, 1'b0);
      send("posext", 31, -32, 31, 20, 31, 1'b0);
      send("negext", -32, 31, -32, 5, -32, 1'b0);

      // Windup from reset with e=63 every sample.
      do_reset();
`ifdef PID_TERM_GEN_ANTI_WINDUP_EN
      hi = 127;
`else
      hi = 511;
`endif
      acc_m = 0;
      for (int k = 0; k < 9; k++) begin
         acc_m = (acc_m + 63 > hi) ? hi : acc_m + 63;
         send($sformatf("wind%0d", k), 31, -32, 31,
              (acc_m / 4 > 31) ? 31 : acc_m / 4, 0, 1'b0);
      end
`ifdef PID_TERM_GEN_ANTI_WINDUP_EN
      send("unwind0", -32, 31, -32, 16, -32, 1'b0);
`else
      send("unwind0", -32, 31, -32, 31, -32, 1'b0);
      send("unwind1", -32, 31, -32, 31, 0, 1'b0);
`endif

      // sample_valid held high: one pulse every 4 cycles.
      do_reset();
      setpoint     = 6'd5;
      measurement  = 6'd0;
      sample_valid = 1'b1;
      n = 0; first = -1; last = -1;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         if (contrib_valid) begin
            n++;
            if (first < 0) first = c;
            last = c;
         end
      end
      sample_valid = 1'b0;
      check("hs.count", n, 4);
      check("hs.first", first, 3);
      check("hs.span", last - first, 12);

      // ena low for 5 cycles while in flight.
      do_reset();
      setpoint     = 6'd20;
      measurement  = 6'd10;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      ena = 1'b0;
      bc = 0; vc = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (busy) bc++;
         if (contrib_valid) vc++;
      end
      ena = 1'b1;
      cnt = 6;
      while (!contrib_valid && cnt < 30) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("ena.lat", cnt, 8);
      check("ena.busy", bc, 5);
      check("ena.early", vc, 0);
      check("ena.P", sx6(p_contrib), 10);
      check("ena.I", sx6(i_contrib), 2);
      @(posedge clk); #1;

      // integ_clr beats sample_valid in IDLE.
      integ_clr    = 1'b1;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      integ_clr    = 1'b0;
      sample_valid = 1'b0;
      vc = 0; bc = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (contrib_valid) vc++;
         if (busy) bc++;
      end
      check("clr.valid", vc, 0);
      check("clr.busy", bc, 0);
      send("clr_after", 20, 10, 10, 2, 0, 1'b0);
      send("clr_flight", 20, 10, 10, 2, 0, 1'b1);

      // Reset during UPD aborts the sample.
      setpoint     = 6'd20;
      measurement  = 6'd10;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mrst.P", sx6(p_contrib), 0);
      check("mrst.I", sx6(i_contrib), 0);
      check("mrst.D", sx6(d_contrib), 0);
      check("mrst.valid", int'(contrib_valid), 0);
      check("mrst.busy", int'(busy), 0);
      #4 rst_n = 1'b1;
      vc = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (contrib_valid) vc++;
      end
      check("mrst.nopulse", vc, 0);
      send("mrst_after", 20, 10, 10, 2, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pid_term_gen.md
Name: pid_term_gen

Overview:
- Front end of the PID path: turns setpoint/measurement samples into the signed 6-bit p_contrib, i_contrib and d_contrib terms that the PID summer consumes.
- Holds the error, the previous-error register and a saturating integrator.
- Issues one valid pulse per accepted sample.
- Gains are power-of-two arithmetic right shifts, so the block needs no multipliers.

Parameters:
- P_SHIFT, 0, arithmetic right shift applied to the error for the P term
- I_SHIFT, 2, arithmetic right shift applied to the integrator for the I term
- D_SHIFT, 0, arithmetic right shift applied to the error difference for the D term
- ACC_W, 10, integrator width in bits, signed

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; low freezes all state
- setpoint  in  6  signed target value
- measurement  in  6  signed plant feedback
- sample_valid  in  1  sample strobe
- integ_clr  in  1  synchronous integrator and history clear
- busy  out  1  high while a sample is in flight
- p_contrib  out  6  signed P term
- i_contrib  out  6  signed I term
- d_contrib  out  6  signed D term
- contrib_valid  out  1  one-cycle pulse when the terms update

Behaviour:
- Reset (asynchronous, rst_n=0):
  - outputs: all contribs=0, contrib_valid=0, busy=0.
  - internal: acc=0, e_prev=0, primed=0, FSM=IDLE.
  - Reset mid-operation aborts the sample; no valid pulse is issued.
- FSM: IDLE -> ERR -> UPD -> OUT -> IDLE. Each step advances only on clock edges where ena=1.
- IDLE:
  - sample_valid=1 with ena=1 latches setpoint and measurement, then goes to ERR.
  - busy rises on the next cycle.
- ERR: e = setpoint - measurement, sign-extended to 7 bits (range -63..63), registered.
- UPD:
  - acc = sat_ACC_W(acc + e).
  - diff = primed ? (e - e_prev) : 0, 8-bit signed.
  - e_prev = e; primed = 1.
- OUT:
  - p_contrib = sat6(e >>> P_SHIFT).
  - i_contrib = sat6(acc >>> I_SHIFT), using the updated acc.
  - d_contrib = sat6(diff >>> D_SHIFT).
  - contrib_valid=1 for exactly this cycle; busy falls; return to IDLE.
- Latency: contrib_valid is high in the 3rd cycle after the accepting edge, when ena is held high.
- ena=0 mid-flight: the FSM holds and the pulse is delayed by the number of ena-low cycles. contrib_valid is never stretched.
- sample_valid while busy: ignored (dropped), with no side effects.
- Saturation:
  - sat6 clamps to [-32, 31].
  - sat_ACC_W clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - No wrap-around anywhere.
- Contribs hold their last values between valid pulses.
- integ_clr=1 with ena=1: clears acc, e_prev and primed next edge.
  - In IDLE it takes priority over sample_valid; that sample is dropped.
  - In flight it applies and the in-flight sample continues with cleared history, so UPD sees acc=0 and primed=0.

Optional Feature:
- Macro: PID_TERM_GEN_ANTI_WINDUP_EN.
- Defined: the integrator is clamped to [-(32<<I_SHIFT), (32<<I_SHIFT)-1]; default [-128, 127]. It therefore never winds beyond the range where i_contrib saturates, and recovery from saturation is immediate.
- Undefined: the integrator clamps only at the ACC_W limits.

Test Plan:
- Basic sample: reset, then setpoint=20, meas=10, pulse sample_valid -> valid 3 cycles later with P=10, I=2 (acc=10), D=0 (unprimed); busy high for 2 cycles.
- Repeat and extremes:
  - same sample again -> P=10, I=5 (acc=20), D=0.
  - then setpoint=31, meas=-32 -> P=31 (sat), acc=83, I=20, D=53->31.
- Negative extreme, continuing from the previous case: setpoint=-32, meas=31 -> e=-63, P=-32, acc=20, I=5, D=-126->-32.
- Windup: 9 consecutive samples with e=63 from reset.
  - Macro off -> acc=511, I=31.
  - Then 2 samples with e=-63 -> acc=385, I=31 (still saturated).
  - Macro on -> acc stops at 127, and after one e=-63 sample I=16.
- Handshake and enable:
  - sample_valid asserted every cycle -> exactly one valid per 4 cycles.
  - ena low for 5 cycles mid-flight -> valid delayed by exactly 5 cycles.
  - integ_clr in IDLE together with sample_valid -> sample dropped, acc=0.
- Reset mid-flight: rst_n pulsed low during UPD -> no contrib_valid, all outputs 0. The next sample with e=10 gives D=0 and I=2.
